// File: rtl/pipeline.sv
// pipeline: five-stage in-order 32-bit RISC core with forwarding, load-use stall and EX-resolved branches
module regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  wa,
  input  logic [31:0] wd,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic [3:0]  ra3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3
);
  logic [31:0] r [0:15] = '{default: '0};
  always_ff @(posedge clk)
    if (we && wa != 4'd0) r[wa] <= wd;
  assign rd1 = ra1 == 4'd0 ? '0 : (we && wa == ra1) ? wd : r[ra1];
  assign rd2 = ra2 == 4'd0 ? '0 : (we && wa == ra2) ? wd : r[ra2];
  assign rd3 = ra3 == 4'd0 ? '0 : (we && wa == ra3) ? wd : r[ra3];
endmodule

module memory (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  ia,
  input  logic [9:0]  da,
  input  logic [31:0] wd,
  output logic [31:0] iw,
  output logic [31:0] dw
);
  logic [7:0] mem [0:4095];
  assign iw = {mem[{ia, 2'd3}], mem[{ia, 2'd2}], mem[{ia, 2'd1}], mem[{ia, 2'd0}]};
  assign dw = {mem[{da, 2'd3}], mem[{da, 2'd2}], mem[{da, 2'd1}], mem[{da, 2'd0}]};
  always_ff @(posedge clk)
    if (we) begin
      mem[{da, 2'd0}] <= wd[7:0];
      mem[{da, 2'd1}] <= wd[15:8];
      mem[{da, 2'd2}] <= wd[23:16];
      mem[{da, 2'd3}] <= wd[31:24];
    end
endmodule

module pipeline (
  input logic clk,
  input logic reset
);
  logic [31:0] pc = '0;
  logic        halted = 1'b0;
  logic [31:0] d_ir = '0, d_pc = '0;
  logic [3:0]  e_op = '0, e_rd = '0, e_rs1 = '0, e_rs2 = '0;
  logic        e_we = 1'b0;
  logic [31:0] e_a = '0, e_b = '0, e_c = '0, e_imm = '0, e_pc = '0;
  logic        m_we = 1'b0, m_st = 1'b0, m_ld = 1'b0;
  logic [3:0]  m_rd = '0;
  logic [31:0] m_res = '0, m_sd = '0;
  logic        w_we = 1'b0;
  logic [3:0]  w_rd = '0;
  logic [31:0] w_val = '0;
  logic [31:0] iw, dw, rd1, rd2, rd3, x_a, x_b, x_c, x_res, target;
  logic [3:0]  d_op, d_rd, d_rs1, d_rs2;
  logic        d_use1, d_use2, d_use3, d_wr, stall, halt_id, taken;

  regfile rf1 (.clk(clk), .we(w_we && !reset), .wa(w_rd), .wd(w_val),
               .ra1(d_rs1), .ra2(d_rs2), .ra3(d_rd), .rd1(rd1), .rd2(rd2), .rd3(rd3));
  memory m1 (.clk(clk), .we(m_st && !reset), .ia(pc[11:2]), .da(m_res[11:2]),
             .wd(m_sd), .iw(iw), .dw(dw));

  always_comb begin
    d_op    = d_ir[31:28];
    d_rd    = d_ir[27:24];
    d_rs1   = d_ir[23:20];
    d_rs2   = d_ir[19:16];
    d_use1  = d_op >= 4'd1 && d_op <= 4'd9;
    d_use2  = d_op >= 4'd1 && d_op <= 4'd5;
    d_use3  = d_op == 4'd8 || d_op == 4'd9;
    d_wr    = d_op >= 4'd1 && d_op <= 4'd7 && d_rd != 4'd0;
    halt_id = d_op == 4'hF;
    stall   = e_we && e_op == 4'd7 && ((d_use1 && e_rd == d_rs1) ||
              (d_use2 && e_rd == d_rs2) || (d_use3 && e_rd == d_rd));
  end

  // EX/MEM wins over MEM/WB; a load never sits in EX/MEM with a consumer in EX thanks to the stall
  always_comb begin
    x_a    = (m_we && m_rd == e_rs1) ? m_res : (w_we && w_rd == e_rs1) ? w_val : e_a;
    x_b    = (m_we && m_rd == e_rs2) ? m_res : (w_we && w_rd == e_rs2) ? w_val : e_b;
    x_c    = (m_we && m_rd == e_rd)  ? m_res : (w_we && w_rd == e_rd)  ? w_val : e_c;
    x_res  = e_op == 4'd1 ? x_a + x_b :
             e_op == 4'd2 ? x_a - x_b :
             e_op == 4'd3 ? x_a & x_b :
             e_op == 4'd4 ? x_a | x_b :
             e_op == 4'd5 ? x_a ^ x_b : x_a + e_imm;
    taken  = (e_op == 4'd9 && x_c == x_a) || e_op == 4'hA;
    target = e_pc + 32'd4 + {e_imm[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      halted <= 1'b0;
      d_ir   <= '0;
      d_pc   <= '0;
      e_op   <= '0;
      e_rd   <= '0;
      e_rs1  <= '0;
      e_rs2  <= '0;
      e_we   <= 1'b0;
      e_a    <= '0;
      e_b    <= '0;
      e_c    <= '0;
      e_imm  <= '0;
      e_pc   <= '0;
      m_we   <= 1'b0;
      m_st   <= 1'b0;
      m_ld   <= 1'b0;
      m_rd   <= '0;
      m_res  <= '0;
      m_sd   <= '0;
      w_we   <= 1'b0;
      w_rd   <= '0;
      w_val  <= '0;
    end else begin
      if (taken) begin
        pc   <= target;
        d_ir <= '0;
      end else if (!stall) begin
        if (halted || halt_id) begin
          halted <= 1'b1;
          d_ir   <= '0;
        end else begin
          pc   <= pc + 32'd4;
          d_ir <= iw;
          d_pc <= pc;
        end
      end
      e_op  <= (taken || stall) ? 4'd0 : d_op;
      e_we  <= !(taken || stall) && d_wr;
      e_rd  <= d_rd;
      e_rs1 <= d_rs1;
      e_rs2 <= d_rs2;
      e_a   <= rd1;
      e_b   <= rd2;
      e_c   <= rd3;
      e_imm <= {{16{d_ir[15]}}, d_ir[15:0]};
      e_pc  <= d_pc;
      m_we  <= e_we;
      m_st  <= e_op == 4'd8;
      m_ld  <= e_op == 4'd7;
      m_rd  <= e_rd;
      m_res <= x_res;
      m_sd  <= x_c;
      w_we  <= m_we;
      w_rd  <= m_rd;
      w_val <= m_ld ? dw : m_res;
    end
  end
endmodule

// File: tb/tb_pipeline.sv
// tb_pipeline: directed programs plus random programs checked against an instruction-level interpreter
module tb_pipeline;
  logic clk = 1'b0, reset = 1'b1;
  int n_chk = 0, n_pass = 0;
  logic [31:0] prog [$];
  logic [7:0]  mm [0:4095];
  logic [31:0] mr [0:15];
  logic [31:0] s1, s2, sm;

  pipeline dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ins(input int op, input int rd, input int rs1, input int rs2, input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] mw(input logic [31:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {mm[b + 12'd3], mm[b + 12'd2], mm[b + 12'd1], mm[b]};
  endfunction

  function automatic logic [31:0] dword(input logic [11:0] a);
    return {dut.m1.mem[a + 12'd3], dut.m1.mem[a + 12'd2], dut.m1.mem[a + 12'd1], dut.m1.mem[a]};
  endfunction

  task automatic poke(input int a, input logic [31:0] w);
    for (int j = 0; j < 4; j++) begin
      int b;
      b = a + j;
      mm[b[11:0]] = w[8*j +: 8];
    end
  endtask

  task automatic prep();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) dut.rf1.r[i[3:0]] = '0;
    for (int i = 0; i < 4096; i++) mm[i[11:0]] = '0;
    foreach (prog[k]) poke(4 * k, prog[k]);
  endtask

  // sequential ISA interpreter: registers and memory after the program halts
  task automatic model();
    logic [31:0] pc, ir, a, b, c, imm, ea;
    logic [3:0]  op, rd;
    pc = '0;
    for (int i = 0; i < 16; i++) mr[i[3:0]] = '0;
    for (int s = 0; s < 4000; s++) begin
      ir  = mw(pc);
      op  = ir[31:28];
      rd  = ir[27:24];
      a   = mr[ir[23:20]];
      b   = mr[ir[19:16]];
      c   = mr[rd];
      imm = {{16{ir[15]}}, ir[15:0]};
      ea  = a + imm;
      if (op == 4'hF) break;
      if (rd != 4'd0)
        case (op)
          4'd1: mr[rd] = a + b;
          4'd2: mr[rd] = a - b;
          4'd3: mr[rd] = a & b;
          4'd4: mr[rd] = a | b;
          4'd5: mr[rd] = a ^ b;
          4'd6: mr[rd] = ea;
          4'd7: mr[rd] = mw(ea);
          default: ;
        endcase
      if (op == 4'd8) poke(int'({ea[11:2], 2'b00}), c);
      pc = (op == 4'hA || (op == 4'd9 && c == a)) ? pc + 32'd4 + (imm << 2) : pc + 32'd4;
    end
  endtask

  task automatic go();
    for (int i = 0; i < 4096; i++) dut.m1.mem[i[11:0]] = mm[i[11:0]];
    model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run();
    int c;
    c = 0;
    while (!dut.halted && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("halted", {31'b0, dut.halted}, 32'd1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    // ALU ops without hazards, reset state and writeback latency
    prog.delete();
    prog.push_back(ins(6, 1, 0, 0, 5));
    prog.push_back(ins(6, 2, 0, 0, 7));
    repeat (3) prog.push_back(ins(0, 0, 0, 0, 0));
    prog.push_back(ins(1, 3, 1, 2, 0));
    prog.push_back(ins(2, 4, 2, 1, 0));
    prog.push_back(ins(15, 0, 0, 0, 0));
    prep();
    go();
    check("reset_pc", dut.pc, 32'd0);
    check("reset_halted", {31'b0, dut.halted}, 32'd0);
    repeat (4) @(negedge clk);
    check("lat_edge4_r1", dut.rf1.r[1], 32'd0);
    @(negedge clk);
    check("lat_edge5_r1", dut.rf1.r[1], 32'd5);
    run();
    check("alu_r3", dut.rf1.r[3], 32'h0000000C);
    check("alu_r4", dut.rf1.r[4], 32'h00000002);
    check("halt_pc", dut.pc, 32'd32);
    repeat (5) @(negedge clk);
    check("halt_pc_frozen", dut.pc, 32'd32);

    // back-to-back forwarding
    prog.delete();
    prog.push_back(ins(6, 1, 0, 0, 1));
    repeat (3) prog.push_back(ins(1, 1, 1, 1, 0));
    prog.push_back(ins(15, 0, 0, 0, 0));
    prep();
    go();
    run();
    check("fwd_r1", dut.rf1.r[1], 32'd8);

    // load-use stall and store of the dependent result
    prog.delete();
    prog.push_back(ins(7, 5, 0, 0, 'h100));
    prog.push_back(ins(6, 6, 5, 0, 1));
    prog.push_back(ins(8, 6, 0, 0, 'h104));
    prog.push_back(ins(15, 0, 0, 0, 0));
    prep();
    poke('h100, 32'hDEADBEEF);
    go();
    run();
    check("lu_r5", dut.rf1.r[5], 32'hDEADBEEF);
    check("lu_r6", dut.rf1.r[6], 32'hDEADBEF0);
    check("lu_mem104", dword(12'h104), 32'hDEADBEF0);

    // taken branch flushes the two younger instructions
    prog.delete();
    prog.push_back(ins(6, 1, 0, 0, 3));
    prog.push_back(ins(9, 1, 1, 0, 2));
    prog.push_back(ins(6, 2, 0, 0, 9));
    prog.push_back(ins(6, 2, 0, 0, 9));
    prog.push_back(ins(6, 3, 0, 0, 4));
    prog.push_back(ins(15, 0, 0, 0, 0));
    prep();
    go();
    run();
    check("br_r2", dut.rf1.r[2], 32'd0);
    check("br_r3", dut.rf1.r[3], 32'd4);

    // reset for one edge in the middle of a counting loop
    prog.delete();
    prog.push_back(ins(6, 1, 0, 0, 0));
    prog.push_back(ins(6, 2, 0, 0, 10));
    prog.push_back(ins(6, 1, 1, 0, 1));
    prog.push_back(ins(8, 1, 0, 0, 'h200));
    prog.push_back(ins(9, 1, 2, 0, 1));
    prog.push_back(ins(10, 0, 0, 0, -4));
    prog.push_back(ins(15, 0, 0, 0, 0));
    prep();
    go();
    repeat (20) @(negedge clk);
    s1 = dut.rf1.r[1];
    s2 = dut.rf1.r[2];
    sm = dword(12'h200);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_pc", dut.pc, 32'd0);
    check("rst_mid_r1_hold", dut.rf1.r[1], s1);
    check("rst_mid_r2_hold", dut.rf1.r[2], s2);
    check("rst_mid_mem_hold", dword(12'h200), sm);
    reset = 1'b0;
    run();
    check("rst_rerun_r1", dut.rf1.r[1], 32'd10);
    check("rst_rerun_r2", dut.rf1.r[2], 32'd10);
    check("rst_rerun_mem", dword(12'h200), 32'd10);

    // r0 discards writes and nothing after HALT executes
    prog.delete();
    prog.push_back(ins(6, 0, 0, 0, 5));
    prog.push_back(ins(15, 0, 0, 0, 0));
    prog.push_back(ins(6, 7, 0, 0, 1));
    prep();
    go();
    run();
    check("r0_zero", dut.rf1.r[0], 32'd0);
    check("halt_r7", dut.rf1.r[7], 32'd0);
    check("halt_pc_r0", dut.pc, 32'd8);

    // random straight-line programs with forward branches
    for (int t = 0; t < 6; t++) begin
      prog.delete();
      for (int i = 0; i < 20; i++) begin
        int k, rd, r1, r2, imm;
        k   = $urandom_range(0, 11);
        rd  = $urandom_range(0, 15);
        r1  = $urandom_range(0, 15);
        r2  = $urandom_range(0, 15);
        imm = $urandom_range(0, 65535);
        if (k == 7 || k == 8) begin
          r1  = 0;
          imm = $urandom_range(2048, 2303);
        end
        if (k == 9 || k == 10) imm = $urandom_range(0, (19 - i) < 3 ? (19 - i) : 3);
        if (k == 9 && $urandom_range(0, 1) == 1) r1 = rd;
        if (k == 11) k = $urandom_range(11, 14);
        prog.push_back(ins(k, rd, r1, r2, imm));
      end
      prog.push_back(ins(15, 0, 0, 0, 0));
      prep();
      for (int a = 'h800; a < 'h900; a += 4) poke(a, $urandom());
      go();
      run();
      for (int r = 0; r < 16; r++)
        check($sformatf("rnd%0d_r%0d", t, r), dut.rf1.r[r[3:0]], mr[r[3:0]]);
      for (int a = 'h800; a < 'h900; a += 4)
        check($sformatf("rnd%0d_mem%03h", t, a), dword(a[11:0]), mw(a));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipeline.md
# pipeline

Five-stage, in-order, 32-bit RISC core with 16 general registers and a unified byte-addressed 4 KiB memory. It is the top of the processor design and runs a program preloaded into its memory by the bench, starting at address 0. Results are observed through hierarchical access to the register file (`rf1.r`) and memory (`m1.mem`).

## Interface
- No parameters; sizes are fixed: 16 × 32-bit registers, 4096 × 8-bit memory.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; takes effect on a rising edge of `clk`.
- Required hierarchy, relied on by benches:
  - instance `rf1` holding `reg [31:0] r [0:15]`;
  - instance `m1` holding `reg [7:0] mem [0:4095]`.
- No other ports.

## Operation
- **Stages:** IF, ID, EX, MEM, WB, with pipeline registers between each pair.
- **Memory:** little-endian, so word at address A = {mem[A+3], mem[A+2], mem[A+1], mem[A]}.
  - Addresses are taken modulo 4096.
  - Word accesses ignore address bits [1:0].
  - Fetch and load reads are combinational. Store writes happen on the clock edge in MEM.
- **Instruction format:** op[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0]. imm is sign-extended to 32 bits.
- **Opcodes:**
  - 0 NOP.
  - 1 ADD: rd=rs1+rs2. 2 SUB: rd=rs1−rs2. 3 AND. 4 OR. 5 XOR.
  - 6 ADDI: rd=rs1+imm.
  - 7 LW: rd=word[rs1+imm].
  - 8 SW: word[rs1+imm]=rd.
  - 9 BEQ: if rd==rs1, PC=PC_instr+4+(imm<<2).
  - A JMP: PC=PC_instr+4+(imm<<2).
  - F HALT.
  - B–E: treated as NOP.
- **Arithmetic:** all results are 32-bit modulo; no flags, no exceptions.
- **Register r0:** reads as 0; writes to it are discarded.
- **Register file write-through:** WB writes on the clock edge. An ID read of the register being written in the same cycle returns the new value.
- **Forwarding:** EX operands, including the SW data register rd, are forwarded from EX/MEM (priority) and MEM/WB.
- **Load-use hazard:** if the instruction in ID needs the rd of an LW currently in EX:
  - stall PC and IF/ID for 1 cycle;
  - insert a bubble into EX.
- **Branches:**
  - BEQ and JMP resolve in EX.
  - When taken, the two younger instructions (in IF/ID and ID/EX) are flushed to NOP and PC is loaded with the target.
  - Not-taken BEQ causes no penalty.
- **HALT:** when HALT reaches ID, fetch stops and PC freezes. Older instructions drain normally. The core then idles indefinitely until reset.
- **Reset:**
  - PC=0;
  - all pipeline registers become NOP, with write-enables and store-enables cleared;
  - halt flag cleared.
- **State not touched by reset:** the register file and memory are not cleared by reset, so memory contents preloaded by the bench survive.
- **Power-up values:** PC, pipeline registers and halt flag also take their reset values at time 0 (initial values). A reset pulse that contains no clock edge therefore still yields a clean start. Register file initial value is 0.

## Timing
- One instruction is fetched per cycle when there is no hazard.
- Latency: instruction fetched at edge n writes its register at edge n+4.
- A store is visible in memory after its MEM edge, i.e. at fetch edge +3.
- Load-use hazard: +1 cycle. Taken branch or jump: +2 cycles.
- Reset asserted mid-program: on the next edge all in-flight instructions are discarded and fetch restarts at address 0. No partial store or writeback occurs on that edge.
- A stall and a taken branch in the same cycle: the branch wins (it is older); the stalled instruction is flushed.
- A store and a fetch to the same word in the same cycle: the fetch returns the old data.

## Test plan
- **ALU ops, no hazards:**
  - program: ADDI r1,r0,5; ADDI r2,r0,7; 3 NOPs; ADD r3,r1,r2; SUB r4,r2,r1; HALT;
  - expect r3=0x0000000C and r4=0x00000002 after ~20 cycles, with PC frozen afterwards.
- **Forwarding:** ADDI r1,r0,1; ADD r1,r1,r1 (×3 back-to-back) -> r1=8.
- **Load-use stall:**
  - preload word 0x100=0xDEADBEEF;
  - program: LW r5,r0,0x100; ADDI r6,r5,1 -> r6=0xDEADBEF0.
  - SW r6,r0,0x104 -> mem[0x104..0x107]=F0,BE,AD,DE.
- **Branch flush:** ADDI r1,r0,3; BEQ r1,r1,+2; ADDI r2,r0,9; ADDI r2,r0,9; ADDI r3,r0,4 -> r2=0, r3=4.
- **Reset mid-run:** assert reset for one edge during a loop -> PC=0, no register or memory writes on that edge, and the program reruns to the same final values.
- **r0 and HALT:** ADDI r0,r0,5; HALT; ADDI r7,r0,1 -> r0 reads 0 and r7 stays 0.
